stream_frame_mux: RTL
=====================

Name: stream_frame_mux

Overview:
- Parametrised N-channel pixel-stream selector for the video pipeline. Sits between multiple pixel sources (demosaic, scaler, capture) and one sink such as the VGA framebuffer writer.
- On a start pulse it latches a channel and a frame resolution. It then forwards exactly one frame of pixels through an internal elastic FIFO, using the pipeline's dIn/dInValid/nextDin and dOut/dOutValid/nextDout handshake.
- Channel switching happens only at frame boundaries, so no torn frames reach the sink.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 8, pixel width in bits.
- FIFO_DEPTH, 8, elastic buffer entries; power of 2, >=2.
- RES_W, 11, width of resolution and counter fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start request.
- chSel  in  max(1,$clog2(NUM_CH))  channel to forward; sampled on start.
- xRes  in  RES_W  frame width minus 1; sampled on start.
- yRes  in  RES_W  frame height minus 1; sampled on start.
- dIn  in  NUM_CH*DATA_W  packed channel pixels; channel c occupies [c*DATA_W +: DATA_W].
- dInValid  in  NUM_CH  per-channel pixel valid.
- nextDin  out  NUM_CH  per-channel request/ready.
- dOut  out  DATA_W  output pixel.
- dOutValid  out  1  output pixel valid.
- nextDout  in  1  sink ready.
- lineEnd  out  1  qualifies dOut as last pixel of a line.
- frameEnd  out  1  qualifies dOut as last pixel of the frame.
- busy  out  1  high in RUN or DRAIN.
- selErr  out  1  one-cycle pulse when start is rejected for out-of-range chSel.
- patternMode  in  1  test-pattern select; see Optional Feature.

Behaviour:
- Reset:
  - state=IDLE; FIFO empty; counters cleared.
  - All outputs are 0: nextDin, dOutValid, dOut, lineEnd, frameEnd, busy, selErr.
- Transfers:
  - Input beat on channel c when dInValid[c] && nextDin[c].
  - Output beat when dOutValid && nextDout.
- States:
  - IDLE:
    - start && chSel<NUM_CH: latch chSel, xRes, yRes; clear x/y counters; go to RUN next cycle.
    - start && chSel>=NUM_CH: selErr=1 for one cycle; stay in IDLE.
  - RUN:
    - nextDin[sel] = !fifoFull. It is derived from registered state and count only, so it is not affected by a same-cycle pop.
    - All other nextDin bits are 0.
    - Each input beat pushes {pixel, x==xRes, x==xRes&&y==yRes}.
    - Counters: x increments per beat; when x==xRes, x wraps to 0 and y increments.
    - The beat with x==xRes && y==yRes moves the block to DRAIN. nextDin is 0 from the next cycle.
  - DRAIN:
    - No input requests.
    - When the FIFO is empty and no pop is pending, go to IDLE.
- FIFO:
  - First-word-fall-through.
  - dOutValid = !empty. dOut, lineEnd and frameEnd come from the head entry.
  - Simultaneous push and pop leave the count unchanged. Count width is $clog2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
- Timing:
  - Latency from input beat to dOutValid is 1 cycle when the FIFO is empty.
  - Sustained throughput is 1 pixel/clk when nextDout is held high.
- start while busy is ignored; no selErr is raised.
- Mid-frame reset aborts the frame: FIFO is flushed, state returns to IDLE, and no partial frame remains.
- busy = (state != IDLE).

Optional Feature:
- Macro: STREAM_FRAME_MUX_PATTERN_EN.
- Defined:
  - patternMode is sampled on start.
  - If it was high, RUN ignores dIn and dInValid, and all nextDin bits are 0.
  - Each cycle with !fifoFull pushes the pixel (x+y) mod 2^DATA_W, with the same counters, flags and frame termination.
- Undefined:
  - patternMode is ignored; the port remains present so wrappers are unchanged.
  - No pattern logic is synthesised.

Decomposition:
- Shared package (stream_pkg):
  - state enum (IDLE/RUN/DRAIN);
  - function for chSel width max(1,$clog2(NUM_CH));
  - FIFO entry typedef {data, lineEnd, frameEnd}.
- One sub-module: stream_fifo_fwft, parametrised DATA_W+2 and FIFO_DEPTH, with push/pop/full/empty/count.
- Top-level holds the FSM, channel mux and x/y counters.

Test Plan:
- Basic frame:
  - Stimulus: NUM_CH=4, start with chSel=2, xRes=3, yRes=1. Channel 2 always valid with pixels 0x10..0x17; nextDout=1.
  - Response: 8 output pixels 0x10..0x17 in order; lineEnd on 0x13 and 0x17; frameEnd only on 0x17; busy drops 1 cycle after the last pop; nextDin[0,1,3] stay 0 throughout.
- Backpressure:
  - Stimulus: FIFO_DEPTH=8, nextDout=0 for 20 cycles during a 16-pixel frame.
  - Response: exactly 8 pixels accepted, then nextDin[sel]=0. Releasing nextDout delivers all 16 pixels with none lost or duplicated.
- Out-of-range channel:
  - Stimulus: start with chSel=5 when NUM_CH=4... (a 2-bit chSel cannot encode 5, so use NUM_CH=3 and chSel=3).
  - Response: selErr pulses one cycle; state stays IDLE; no nextDin raised.
- Start while busy:
  - Stimulus: second start with chSel=0 mid-frame.
  - Response: ignored; the frame completes from the original channel.
- Mid-frame reset:
  - Stimulus: rst asserted after 5 of 16 pixels, with 3 buffered.
  - Response: next cycle dOutValid=0, busy=0, FIFO empty. A new start then runs a clean frame.
- Pattern (macro defined):
  - Stimulus: patternMode=1, xRes=2, yRes=1.
  - Response: output 0,1,2,1,2,3; dInValid is ignored.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg
// Shared types and helpers for the stream_frame_mux block.
//   state_e       : frame sequencer states (idle / run / drain)
//   sel_width()   : channel-select width, max(1, $clog2(num_ch))
//   entry_flags_t : per-pixel framing flags stored alongside each FIFO entry
package stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    function automatic int unsigned sel_width(input int unsigned num_ch);
        return ($clog2(num_ch) < 1) ? 1 : $clog2(num_ch);
    endfunction

    typedef struct packed {
        logic line_end;
        logic frame_end;
    } entry_flags_t;

    localparam int unsigned EntryFlagW = $bits(entry_flags_t);

endpackage

// File: rtl/stream_fifo_fwft.sv
// stream_fifo_fwft
// First-word-fall-through FIFO: the head entry is visible on rdata_o whenever
// empty_o is low. Push while full and pop while empty are ignored.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and data
//   pop_i             : consume head entry
//   rdata_o           : head entry
//   full_o, empty_o   : occupancy flags
//   count_o           : number of stored entries (0..DEPTH)
module stream_fifo_fwft #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly AddrW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the head is only observed while non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/stream_frame_mux.sv
// stream_frame_mux
// N-channel pixel-stream selector. A start pulse latches a channel and frame
// size; exactly one frame is then forwarded through an elastic FWFT FIFO.
// Channels only change between frames, so no torn frames reach the sink.
// Optional feature macro: STREAM_FRAME_MUX_PATTERN_EN (built-in x+y test pattern,
// chosen by patternMode at start). Without it patternMode is ignored.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start, chSel, xRes, yRes: frame request; xRes/yRes are width-1/height-1
//   patternMode             : test-pattern select, sampled on start
//   dIn, dInValid, nextDin  : per-channel input handshake
//   dOut, dOutValid, nextDout: output handshake
//   lineEnd, frameEnd       : framing flags qualifying dOut
//   busy                    : frame in progress (run or drain)
//   selErr                  : one-cycle pulse, the cycle after a start with
//                             out-of-range chSel is rejected
module stream_frame_mux
    import stream_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RES_W      = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [sel_width(NUM_CH)-1:0] chSel,
    input  logic [RES_W-1:0]            xRes,
    input  logic [RES_W-1:0]            yRes,
    input  logic [NUM_CH*DATA_W-1:0]    dIn,
    input  logic [NUM_CH-1:0]           dInValid,
    output logic [NUM_CH-1:0]           nextDin,
    output logic [DATA_W-1:0]           dOut,
    output logic                        dOutValid,
    input  logic                        nextDout,
    output logic                        lineEnd,
    output logic                        frameEnd,
    output logic                        busy,
    output logic                        selErr,
    input  logic                        patternMode
);

    localparam int unsigned SelW = sel_width(NUM_CH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        entry_flags_t      flags;
    } entry_t;

    localparam int unsigned EntryW = $bits(entry_t);

    state_e            state_q, state_d;
    logic [SelW-1:0]   sel_q;
    logic [RES_W-1:0]  xres_q, yres_q, x_q, y_q;
    logic              sel_err_q;
    logic              pat_mode;

    logic              chsel_ok, start_ok;
    logic              req, push, src_valid;
    logic              x_end, last_pix;
    logic [DATA_W-1:0] push_data;
    entry_t            wr_entry, head;
    logic              fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

    assign chsel_ok = (32'(chSel) < NUM_CH);
    assign start_ok = start && chsel_ok;

`ifdef STREAM_FRAME_MUX_PATTERN_EN
    logic pat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= 1'b0;
        end else if (state_q == StIdle && start_ok) begin
            pat_q <= patternMode;
        end
    end

    assign pat_mode = pat_q;
`else
    logic unused_pattern_mode;
    assign unused_pattern_mode = patternMode;
    assign pat_mode = 1'b0;
`endif

    // Source select: the latched channel, or the generated pattern.
    always_comb begin
        src_valid = dInValid[sel_q];
        push_data = dIn[sel_q*DATA_W +: DATA_W];
`ifdef STREAM_FRAME_MUX_PATTERN_EN
        if (pat_mode) begin
            src_valid = 1'b1;
            push_data = DATA_W'(32'(x_q) + 32'(y_q));
        end
`endif
    end

    // Request depends on registered state and count only, never on this
    // cycle's pop, to keep nextDin free of a combinational path from nextDout.
    assign req      = (state_q == StRun) && !fifo_full;
    assign push     = req && src_valid;
    assign x_end    = (x_q == xres_q);
    assign last_pix = x_end && (y_q == yres_q);

    always_comb begin
        nextDin = '0;
        if (req && !pat_mode) nextDin[sel_q] = 1'b1;
    end

    assign wr_entry.data            = push_data;
    assign wr_entry.flags.line_end  = x_end;
    assign wr_entry.flags.frame_end = last_pix;

    stream_fifo_fwft #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (nextDout),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (push && last_pix) state_d = StDrain;
            StDrain: if (fifo_empty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs. Head fields are masked while empty so dOut reads 0 when idle.
    always_comb begin
        busy      = (state_q != StIdle);
        dOutValid = !fifo_empty;
        dOut      = fifo_empty ? '0 : head.data;
        lineEnd   = !fifo_empty && head.flags.line_end;
        frameEnd  = !fifo_empty && head.flags.frame_end;
        selErr    = sel_err_q;
    end

    // Frame parameters and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            xres_q    <= '0;
            yres_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= (state_q == StIdle) && start && !chsel_ok;
            if (state_q == StIdle && start_ok) begin
                sel_q  <= chSel;
                xres_q <= xRes;
                yres_q <= yRes;
                x_q    <= '0;
                y_q    <= '0;
            end else if (push) begin
                if (x_end) begin
                    x_q <= '0;
                    y_q <= y_q + RES_W'(1);
                end else begin
                    x_q <= x_q + RES_W'(1);
                end
            end
        end
    end

endmodule
